// File: rtl/seq_pattern_tx_if.sv
// Bus between the pattern transmitter and whatever drives it.
// The master modport is the requester side. The slave modport is the transmitter side.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] frames;
  logic             abort;
  logic             tx_bit;
  logic             tx_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, frames, abort,
    input  tx_bit, tx_valid, busy, done
  );

  modport slave (
    input  start, pattern, frames, abort,
    output tx_bit, tx_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter.
// On start, the pattern is latched and sent MSB-first, one bit per clock.
// The pattern repeats for the requested number of frames.
// Frames are separated by GAP_CYCLES idle cycles, or sent back-to-back when that is 0.
module seq_pattern_tx #(
  parameter int WIDTH      = 3,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              reset_n,
  seq_pattern_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One counter serves both bit position (SHIFT) and gap length (GAP).
  localparam int MAXC = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;     // bits still to go in the current frame
  logic [WIDTH-1:0] pat_q, pat_d;   // copy of the pattern, reloaded for each frame
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] frm_q, frm_d;   // frames left, including the one in flight

  // State and datapath registers.
  // NOTE: non-blocking assignments here make every flop sample its value from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
    end
  end

  // Next-state and datapath update.
  // abort overrides everything outside IDLE.
  always_comb begin
    // NOTE: every signal is given its hold value first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.frames != '0) begin
            state_d = SHIFT;
            sr_d    = bus.pattern;
            pat_d   = bus.pattern;
            frm_d   = bus.frames;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          frm_d = frm_q - CNT_W'(1);
          cnt_d = '0;
          if (frm_q != CNT_W'(1)) begin
            if (GAP_CYCLES > 0) state_d = GAP;
            else                sr_d    = pat_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = SHIFT;
          sr_d    = pat_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      frm_d   = '0;
    end
  end

  // Outputs are decoded only from flops.
  // They therefore change cleanly at the edge and clear immediately on reset.
  always_comb begin
    bus.tx_bit   = 1'b0;
    bus.tx_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.tx_bit   = sr_q[WIDTH-1];
        bus.tx_valid = 1'b1;
        bus.busy     = 1'b1;
      end
      GAP:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx.
// dut0 sends frames back-to-back. dut2 inserts two gap cycles between frames.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt0 = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(3), .CNT_W(8)) if0 ();
  seq_pattern_tx_if #(.WIDTH(3), .CNT_W(8)) if2 ();

  seq_pattern_tx #(.WIDTH(3), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );

  seq_pattern_tx #(.WIDTH(3), .GAP_CYCLES(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2.slave)
  );

  always @(posedge clk) if (if0.done === 1'b1) done_cnt0++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp0(input string tag, input logic b, input logic v, input logic bs, input logic d);
    check({tag, ".tx_bit"},   32'(if0.tx_bit),   32'(b));
    check({tag, ".tx_valid"}, 32'(if0.tx_valid), 32'(v));
    check({tag, ".busy"},     32'(if0.busy),     32'(bs));
    check({tag, ".done"},     32'(if0.done),     32'(d));
  endtask

  task automatic exp2(input string tag, input logic b, input logic v, input logic bs, input logic d);
    check({tag, ".tx_bit"},   32'(if2.tx_bit),   32'(b));
    check({tag, ".tx_valid"}, 32'(if2.tx_valid), 32'(v));
    check({tag, ".busy"},     32'(if2.busy),     32'(bs));
    check({tag, ".done"},     32'(if2.done),     32'(d));
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] s3;
    logic [7:0] gb, gv;
    int d0, n, vcnt;
    s3 = 9'b110110110;
    gb = 8'b10100101;
    gv = 8'b11100111;

    // Reset.
    reset_n = 1'b0;
    if0.start = 1'b0; if0.pattern = '0; if0.frames = '0; if0.abort = 1'b0;
    if2.start = 1'b0; if2.pattern = '0; if2.frames = '0; if2.abort = 1'b0;
    repeat (3) step;
    exp0("rst0", 0, 0, 0, 0);
    exp2("rst2", 0, 0, 0, 0);
    reset_n = 1'b1;
    step;

    // Single frame 110. The pattern input changes right after acceptance.
    d0 = done_cnt0;
    if0.pattern = 3'b110; if0.frames = 8'd1; if0.start = 1'b1;
    step;
    if0.start = 1'b0; if0.pattern = 3'b001;
    exp0("single.c11", 1, 1, 1, 0); step;
    exp0("single.c12", 1, 1, 1, 0); step;
    exp0("single.c13", 0, 1, 1, 0); step;
    exp0("single.c14", 0, 0, 0, 1); step;
    exp0("single.c15", 0, 0, 0, 0);
    check("single.done_count", 32'(done_cnt0 - d0), 32'd1);

    // Three frames back-to-back. A start pulse during busy must be ignored.
    d0 = done_cnt0;
    if0.pattern = 3'b110; if0.frames = 8'd3; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp0($sformatf("b2b.bit%0d", i), s3[8-i], 1, 1, 0);
      if (i == 3) begin
        if0.start = 1'b1; if0.frames = 8'd1; if0.pattern = 3'b011;
      end
      if (i == 4) if0.start = 1'b0;
      step;
    end
    exp0("b2b.done", 0, 0, 0, 1); step;
    exp0("b2b.idle", 0, 0, 0, 0);
    check("b2b.done_count", 32'(done_cnt0 - d0), 32'd1);

    // Zero frames: done comes on the next cycle and no bit is sent.
    d0 = done_cnt0;
    if0.frames = 8'd0; if0.pattern = 3'b111; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    exp0("zero.c11", 0, 0, 0, 1); step;
    exp0("zero.c12", 0, 0, 0, 0);
    check("zero.done_count", 32'(done_cnt0 - d0), 32'd1);

    // Two-cycle gap: 101, gap, gap, 101, done.
    if2.pattern = 3'b101; if2.frames = 8'd2; if2.start = 1'b1;
    step;
    if2.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp2($sformatf("gap.c%0d", 11 + i), gb[7-i], gv[7-i], 1, 0);
      step;
    end
    exp2("gap.done", 0, 0, 0, 1); step;
    exp2("gap.idle", 0, 0, 0, 0);

    // Abort on the fifth bit. The restart asserts start and abort together.
    d0 = done_cnt0;
    if0.pattern = 3'b110; if0.frames = 8'd3; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp0($sformatf("abort.c%0d", 11 + i), s3[8-i], 1, 1, 0);
      if (i == 4) if0.abort = 1'b1;
      step;
    end
    exp0("abort.c16", 0, 0, 0, 0);
    if0.abort = 1'b0;
    step;
    exp0("abort.c17", 0, 0, 0, 0);
    if0.start = 1'b1; if0.abort = 1'b1; if0.pattern = 3'b011; if0.frames = 8'd1;
    step;
    if0.start = 1'b0; if0.abort = 1'b0;
    exp0("abort.c18", 0, 1, 1, 0); step;
    exp0("abort.c19", 1, 1, 1, 0); step;
    exp0("abort.c20", 1, 1, 1, 0); step;
    exp0("abort.c21", 0, 0, 0, 1); step;
    check("abort.done_count", 32'(done_cnt0 - d0), 32'd1);

    // Reset mid-frame clears the outputs at once. No partial frame resumes afterwards.
    d0 = done_cnt0;
    if0.pattern = 3'b111; if0.frames = 8'd3; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    exp0("rstmid.c11", 1, 1, 1, 0);
    step;
    reset_n = 1'b0;
    #1;
    exp0("rstmid.async", 0, 0, 0, 0);
    repeat (3) step;
    reset_n = 1'b1;
    step;
    exp0("rstmid.after", 0, 0, 0, 0);
    check("rstmid.done_count", 32'(done_cnt0 - d0), 32'd0);
    if0.pattern = 3'b010; if0.frames = 8'd1; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    exp0("rstmid.b0", 0, 1, 1, 0); step;
    exp0("rstmid.b1", 1, 1, 1, 0); step;
    exp0("rstmid.b2", 0, 1, 1, 0); step;
    exp0("rstmid.done", 0, 0, 0, 1); step;

    // Maximum frame count: 255 frames of 3 bits gives 765 valid cycles before done.
    if0.pattern = 3'b100; if0.frames = 8'd255; if0.start = 1'b1;
    step;
    if0.start = 1'b0;
    n = 0; vcnt = 0;
    while (if0.done !== 1'b1 && n < 3000) begin
      if (if0.tx_valid === 1'b1) vcnt++;
      n++;
      step;
    end
    check("maxf.done_seen", 32'(if0.done), 32'd1);
    check("maxf.latency", 32'(n), 32'd765);
    check("maxf.valid_cycles", 32'(vcnt), 32'd765);
    step;
    exp0("maxf.idle", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
